// File: rtl/branch_resolver.sv
// Purpose: in-order queue of predicted conditional branches; resolves the head against its operands (stats under BRANCH_RESOLVER_STATS_EN).
// Latency: update/mispredict strobes and corrected PC are registered one cycle after the pop; a mispredict flushes the queue on that edge.
// Backpressure: none; a push into a full queue without a pop is dropped and sets sticky o_hata; a pop while empty is ignored and sets o_hata.
module branch_resolver #(
    parameter int DERINLIK = 4
) (
    input  logic                          i_saat,
    input  logic                          i_reset,
    input  logic                          i_ongoru_gecerli,
    input  logic                          i_ongoru,
    input  logic [31:0]                   i_buyruk_sayaci,
    input  logic [31:0]                   i_buyruk,
    input  logic                          i_coz_gecerli,
    input  logic [31:0]                   i_rs1,
    input  logic [31:0]                   i_rs2,
    output logic                          o_buyruk_atladi,
    output logic                          o_guncelle_gecerli,
    output logic                          o_ongoru_yanlis,
    output logic [31:0]                   o_dogru_adres,
    output logic                          o_dolu,
    output logic                          o_bos,
    output logic [$clog2(DERINLIK):0]     o_doluluk,
    output logic                          o_hata,
    output logic [31:0]                   o_toplam_dallanma,
    output logic [31:0]                   o_yanlis_sayisi
);
    localparam int AW = $clog2(DERINLIK);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic        ongoru;
        logic [2:0]  funct3;
        logic [31:0] imm;
    } giris_t;

    giris_t        kuyruk [DERINLIK];
    logic [AW-1:0] yaz_ptr;
    logic [AW-1:0] oku_ptr;
    logic [CW-1:0] sayac;

    giris_t        yeni;
    giris_t        bas;
    logic          bos;
    logic          dolu;
    logic          pop_ok;
    logic          push_ok;
    logic          atladi;
    logic          kural_disi;
    logic          yanlis;
    logic          hata_set;
    logic [31:0]   hedef;

    // Only funct3 and the B-type immediate bits are kept; the register fields are unused here.
    logic unused_buyruk;
    assign unused_buyruk = ^{i_buyruk[24:15], i_buyruk[6:0]};

    always_comb begin
        yeni        = '0;
        yeni.pc     = i_buyruk_sayaci;
        yeni.ongoru = i_ongoru;
        yeni.funct3 = i_buyruk[14:12];
        yeni.imm    = {{20{i_buyruk[31]}}, i_buyruk[7], i_buyruk[30:25], i_buyruk[11:8], 1'b0};
    end

    assign bos    = (sayac == '0);
    assign dolu   = (sayac == CW'(DERINLIK));
    assign bas    = kuyruk[oku_ptr];
    assign pop_ok = i_coz_gecerli && !bos;

    always_comb begin
        atladi     = 1'b0;
        kural_disi = 1'b0;
        case (bas.funct3)
            3'b000:  atladi = (i_rs1 == i_rs2);
            3'b001:  atladi = (i_rs1 != i_rs2);
            3'b100:  atladi = ($signed(i_rs1) <  $signed(i_rs2));
            3'b101:  atladi = ($signed(i_rs1) >= $signed(i_rs2));
            3'b110:  atladi = (i_rs1 <  i_rs2);
            3'b111:  atladi = (i_rs1 >= i_rs2);
            default: kural_disi = 1'b1;
        endcase
    end

    assign hedef  = atladi ? (bas.pc + bas.imm) : (bas.pc + 32'd4);
    assign yanlis = pop_ok && (atladi != bas.ongoru);

    // A push in the mispredicting cycle is wrong-path and never enters the queue.
    assign push_ok  = i_ongoru_gecerli && (!dolu || pop_ok) && !yanlis;
    assign hata_set = (i_ongoru_gecerli && dolu && !pop_ok)
                    || (i_coz_gecerli && bos)
                    || (pop_ok && kural_disi);

    always_ff @(posedge i_saat) begin
        if (push_ok) begin
            kuyruk[yaz_ptr] <= yeni;
        end
    end

    always_ff @(posedge i_saat) begin
        if (i_reset) begin
            yaz_ptr            <= '0;
            oku_ptr            <= '0;
            sayac              <= '0;
            o_buyruk_atladi    <= 1'b0;
            o_guncelle_gecerli <= 1'b0;
            o_ongoru_yanlis    <= 1'b0;
            o_dogru_adres      <= '0;
            o_hata             <= 1'b0;
        end else begin
            o_guncelle_gecerli <= pop_ok;
            o_ongoru_yanlis    <= yanlis;
            if (pop_ok) begin
                o_buyruk_atladi <= atladi;
                o_dogru_adres   <= hedef;
            end
            if (hata_set) begin
                o_hata <= 1'b1;
            end
            if (yanlis) begin
                yaz_ptr <= '0;
                oku_ptr <= '0;
                sayac   <= '0;
            end else begin
                if (push_ok) begin
                    yaz_ptr <= yaz_ptr + AW'(1);
                end
                if (pop_ok) begin
                    oku_ptr <= oku_ptr + AW'(1);
                end
                case ({push_ok, pop_ok})
                    2'b10:   sayac <= sayac + CW'(1);
                    2'b01:   sayac <= sayac - CW'(1);
                    default: sayac <= sayac;
                endcase
            end
        end
    end

    assign o_bos     = bos;
    assign o_dolu    = dolu;
    assign o_doluluk = sayac;

`ifdef BRANCH_RESOLVER_STATS_EN
    logic [31:0] toplam_q;
    logic [31:0] yanlis_q;

    always_ff @(posedge i_saat) begin
        if (i_reset) begin
            toplam_q <= '0;
            yanlis_q <= '0;
        end else begin
            if (pop_ok) begin
                toplam_q <= toplam_q + 32'd1;
            end
            if (yanlis) begin
                yanlis_q <= yanlis_q + 32'd1;
            end
        end
    end

    assign o_toplam_dallanma = toplam_q;
    assign o_yanlis_sayisi   = yanlis_q;
`else
    assign o_toplam_dallanma = '0;
    assign o_yanlis_sayisi   = '0;
`endif

endmodule
